sync_updown_counter: RTL and testbench

Parametrised synchronous counter, the next generation of the team's 2-bit JK toggle counter.
- Generalises width and adds up/down direction, count enable and parallel load.
- Adds a programmable modulus, wrap or saturate mode, a terminal-count output for cascading, and a registered wrap pulse.
- Used as a general-purpose divider, sequencer or timer in datapath and control blocks; cascadable via en/tc.

---
 rtl/sync_updown_counter_pkg.sv | 50 +++++
 rtl/sync_updown_counter_if.sv | 25 ++
 rtl/sync_updown_counter_next_state.sv | 27 ++
 rtl/sync_updown_counter.sv | 58 +++++
 tb/tb_sync_updown_counter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/sync_updown_counter_pkg.sv
// Shared constants and the next-count rule for the up/down counter family.
// The rule is written once here so every width of counter steps identically.
package sync_updown_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int MAX_WIDTH = 32;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] value;
        logic                 wrap;
    } count_step_t;

    // Out-of-range values (q > modulus) are pulled back into 0..modulus
    // rather than being allowed to run on to the natural binary overflow.
    function automatic count_step_t next_count(
        input logic [MAX_WIDTH-1:0] q,
        input logic [MAX_WIDTH-1:0] modulus,
        input logic                 up_dn,
        input logic                 sat_mode
    );
        count_step_t res;
        res.value = q;
        res.wrap  = 1'b0;
        if (up_dn == DIR_UP) begin
            if (q < modulus) begin
                res.value = q + 1'b1;
            end else if (sat_mode == MODE_SAT) begin
                res.value = modulus;
            end else begin
                res.value = '0;
                res.wrap  = 1'b1;
            end
        end else begin
            if (q > modulus) begin
                res.value = modulus;
            end else if (q != '0) begin
                res.value = q - 1'b1;
            end else if (sat_mode == MODE_WRAP) begin
                res.value = modulus;
                res.wrap  = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_updown_counter_if.sv
// Control and status bundle of one counter stage; clk/reset travel separately.
interface sync_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] modulus;
    logic             sat_mode;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] qbar_out;
    logic             tc;
    logic             wrap_pulse;

    modport master (
        output en, up_dn, load, load_val, modulus, sat_mode,
        input  q_out, qbar_out, tc, wrap_pulse
    );

    modport slave (
        input  en, up_dn, load, load_val, modulus, sat_mode,
        output q_out, qbar_out, tc, wrap_pulse
    );
endinterface

// File: rtl/sync_updown_counter_next_state.sv
// Combinational counting step: next count value and wrap flag for one enabled edge.
module sync_updown_counter_next_state
    import sync_updown_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] modulus,
    input  logic             up_dn,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] next_q,
    output logic             wrap
);

    count_step_t step;
    logic        unused_step_hi;

    always_comb begin
        step = next_count(MAX_WIDTH'(q), MAX_WIDTH'(modulus), up_dn, sat_mode);
    end

    // The result never exceeds modulus, so the bits above WIDTH are always zero.
    assign next_q         = step.value[WIDTH-1:0];
    assign wrap           = step.wrap;
    assign unused_step_hi = ^step.value;

endmodule

// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with load, modulus, wrap/saturate
// mode, terminal count for cascading and a registered wrap pulse.
module sync_updown_counter #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                 clk,
    input logic                 reset,
    sync_updown_counter_if.slave bus
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_pulse_q;
    logic             wrap_pulse_d;
    logic [WIDTH-1:0] step_q;
    logic             step_wrap;

    sync_updown_counter_next_state #(
        .WIDTH(WIDTH)
    ) u_next_state (
        .q        (count_q),
        .modulus  (bus.modulus),
        .up_dn    (bus.up_dn),
        .sat_mode (bus.sat_mode),
        .next_q   (step_q),
        .wrap     (step_wrap)
    );

    // Load beats counting; reset is applied on top of this in the register.
    always_comb begin
        count_d      = count_q;
        wrap_pulse_d = 1'b0;
        if (bus.load) begin
            count_d = bus.load_val;
        end else if (bus.en) begin
            count_d      = step_q;
            wrap_pulse_d = step_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= RESET_VAL;
            wrap_pulse_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    assign bus.q_out      = count_q;
    assign bus.qbar_out   = ~count_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.tc         = bus.en & ((bus.up_dn & (count_q == bus.modulus)) |
                                      (~bus.up_dn & (count_q == '0)));

endmodule

// File: tb/tb_sync_updown_counter.sv
// Randomised and directed scoreboard bench for sync_updown_counter, plus a
// two-stage cascade built from the terminal-count output.
module tb_sync_updown_counter;

    localparam int               WIDTH = 4;
    localparam logic [WIDTH-1:0] RVAL  = 4'd5;

    typedef struct {
        int q;
        int w;
        int tc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic casc_reset;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_q  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sync_updown_counter_if #(.WIDTH(WIDTH)) dut_if ();
    sync_updown_counter_if #(.WIDTH(WIDTH)) lo_if ();
    sync_updown_counter_if #(.WIDTH(WIDTH)) hi_if ();

    sync_updown_counter #(.WIDTH(WIDTH), .RESET_VAL(RVAL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    sync_updown_counter #(.WIDTH(WIDTH), .RESET_VAL(4'd0)) u_lo (
        .clk   (clk),
        .reset (casc_reset),
        .bus   (lo_if.slave)
    );

    sync_updown_counter #(.WIDTH(WIDTH), .RESET_VAL(4'd0)) u_hi (
        .clk   (clk),
        .reset (casc_reset),
        .bus   (hi_if.slave)
    );

    assign hi_if.en = lo_if.tc;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the counter must show after the edge.
    task automatic applyStimulus(input logic r, input logic e, input logic u,
                                 input logic ld, input int lv, input int md,
                                 input logic s);
        exp_t x;
        int   m;
        int   w;
        @(negedge clk);
        reset           = r;
        dut_if.en       = e;
        dut_if.up_dn    = u;
        dut_if.load     = ld;
        dut_if.load_val = WIDTH'(lv);
        dut_if.modulus  = WIDTH'(md);
        dut_if.sat_mode = s;
        m = model_q;
        w = 0;
        if (r) begin
            m = int'(RVAL);
        end else if (ld) begin
            m = lv;
        end else if (e) begin
            if (u) begin
                if (model_q < md)  m = model_q + 1;
                else if (s)        m = md;
                else begin         m = 0;  w = 1; end
            end else begin
                if (model_q > md)      m = md;
                else if (model_q > 0)  m = model_q - 1;
                else if (s)            m = 0;
                else begin             m = md; w = 1; end
            end
        end
        model_q = m;
        x.q  = m;
        x.w  = w;
        x.tc = (e && ((u && m == md) || (!u && m == 0))) ? 1 : 0;
        sb.push_back(x);
    endtask

    // Monitor: the counter presents a new value after every edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("q_out",      int'(dut_if.q_out),      e.q);
            checkOutput("qbar_out",   int'(dut_if.qbar_out),   (~e.q) & 15);
            checkOutput("wrap_pulse", int'(dut_if.wrap_pulse), e.w);
            checkOutput("tc",         int'(dut_if.tc),         e.tc);
        end
    end

    initial begin
        int md;
        int pulses;
        logic s;

        reset           = 1'b0;
        casc_reset      = 1'b1;
        dut_if.en       = 1'b0;
        dut_if.up_dn    = 1'b1;
        dut_if.load     = 1'b0;
        dut_if.load_val = '0;
        dut_if.modulus  = 4'd15;
        dut_if.sat_mode = 1'b0;
        lo_if.en        = 1'b1;
        lo_if.up_dn     = 1'b1;
        lo_if.load      = 1'b0;
        lo_if.load_val  = '0;
        lo_if.modulus   = 4'd15;
        lo_if.sat_mode  = 1'b0;
        hi_if.up_dn     = 1'b1;
        hi_if.load      = 1'b0;
        hi_if.load_val  = '0;
        hi_if.modulus   = 4'd15;
        hi_if.sat_mode  = 1'b0;

        $display("[TB] reset and first counts");
        repeat (2) applyStimulus(1, 1, 1, 0, 0, 15, 0);
        repeat (3) applyStimulus(0, 1, 1, 0, 0, 15, 0);

        $display("[TB] up, wrap, modulus 9");
        applyStimulus(0, 0, 1, 1, 0, 9, 0);
        repeat (12) applyStimulus(0, 1, 1, 0, 0, 9, 0);

        $display("[TB] down, saturate");
        applyStimulus(0, 0, 0, 1, 2, 9, 1);
        repeat (4) applyStimulus(0, 1, 0, 0, 0, 9, 1);

        $display("[TB] loads above modulus");
        applyStimulus(0, 0, 1, 1, 12, 9, 0);
        applyStimulus(0, 1, 1, 0, 0, 9, 0);
        applyStimulus(0, 0, 0, 1, 12, 9, 0);
        applyStimulus(0, 1, 0, 0, 0, 9, 0);
        applyStimulus(0, 0, 1, 1, 12, 9, 1);
        applyStimulus(0, 1, 1, 0, 0, 9, 1);

        $display("[TB] simultaneous events");
        applyStimulus(0, 0, 1, 1, 7, 15, 0);
        applyStimulus(0, 1, 1, 1, 3, 15, 0);
        applyStimulus(1, 1, 1, 1, 9, 15, 0);
        repeat (3) applyStimulus(0, 0, 1, 0, 0, 15, 0);

        $display("[TB] modulus zero");
        repeat (3) applyStimulus(0, 1, 1, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 1, 1, 0, 0, 0, 1);

        $display("[TB] random phase");
        md = 9;
        s  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) md = $urandom_range(0, 15);
            if ($urandom_range(0, 15) == 0) s = 1'($urandom_range(0, 1));
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 11) == 0),
                          $urandom_range(0, 15), md, s);
        end

        @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("[TB] cascade of two stages");
        @(negedge clk);
        casc_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        casc_reset = 1'b0;
        checkOutput("casc_start", int'({hi_if.q_out, lo_if.q_out}), 0);
        pulses = 0;
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk);
            #1;
            checkOutput("casc_value", int'({hi_if.q_out, lo_if.q_out}), k % 256);
            if (hi_if.wrap_pulse) pulses++;
        end
        checkOutput("casc_upper_wraps", pulses, 1);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
